register_renew_scheduler: RTL

- Front-end controller for the dual-processor register renew manager.
- Accepts renew requests from processor 1 (main) and processor 2 (sub), each naming a target register.
- Arbitrates the shared register_num bus and issues one-cycle boot_renew_register_1/2 pulses.
- Tracks each processor's update until its idle rising edge, and locks the target register so both processors never update the same register concurrently.

---
 rtl/register_renew_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/register_renew_scheduler.sv
// register_renew_scheduler: front-end arbiter for the dual-processor register
// renew manager. Grants one renew request per cycle on the shared register_num
// bus, emits the matching boot pulse, and locks the target register until the
// owning processor signals completion with an idle rising edge.
module register_renew_scheduler #(
    parameter int REGISTER_AMOUNT = 32,
    parameter int REG_CTN_WIDTH   = $clog2(REGISTER_AMOUNT),
    parameter int CNT_WIDTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_1,
    input  logic [REG_CTN_WIDTH-1:0]   req_reg_1,
    output logic                       req_ready_1,
    input  logic                       req_valid_2,
    input  logic [REG_CTN_WIDTH-1:0]   req_reg_2,
    output logic                       req_ready_2,
    input  logic                       processor_idle_1,
    input  logic                       processor_idle_2,
    output logic                       boot_renew_register_1,
    output logic                       boot_renew_register_2,
    output logic [REG_CTN_WIDTH-1:0]   register_num,
    output logic                       busy_1,
    output logic                       busy_2,
    output logic [REGISTER_AMOUNT-1:0] reg_locked,
    output logic                       ra_reject,
    output logic [CNT_WIDTH-1:0]       conflict_count
);

    typedef enum logic {FREE = 1'b0, ACTIVE = 1'b1} trk_state_t;

    // Register 1 (ra) is hardwired in the manager and can never be renewed.
    localparam logic [REG_CTN_WIDTH-1:0] RA_REG = REG_CTN_WIDTH'(1);

    // Index 0 is processor 1 (main), index 1 is processor 2 (sub).
    logic [1:0]               w_valid;
    logic [1:0]               w_idle;
    logic [REG_CTN_WIDTH-1:0] w_req_reg [2];
    logic [1:0]               w_elig;
    logic [1:0]               w_ready;
    logic [1:0]               w_accept;
    logic [1:0]               w_is_ra;
    logic [1:0]               w_issue;
    logic [1:0]               w_done;
    logic [1:0]               w_stall;
    logic [1:0]               w_stall_n;
    logic [CNT_WIDTH:0]       w_cnt_sum;
    logic [CNT_WIDTH-1:0]     w_cnt_next;
    trk_state_t               w_state_next [2];

    trk_state_t               r_state [2];
    logic [REG_CTN_WIDTH-1:0] r_trk_reg [2];
    logic [1:0]               r_boot;
    logic [1:0]               r_idle_prev;
    logic [REGISTER_AMOUNT-1:0] r_locked;
    logic [REG_CTN_WIDTH-1:0] r_register_num;
    logic                     r_ra_reject;
    logic                     r_rr;
    logic [CNT_WIDTH-1:0]     r_conflict;

    assign w_valid      = {req_valid_2, req_valid_1};
    assign w_idle       = {processor_idle_2, processor_idle_1};
    assign w_req_reg[0] = req_reg_1;
    assign w_req_reg[1] = req_reg_2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_proc
            assign w_elig[gi]   = w_valid[gi] && (r_state[gi] == FREE) && !r_locked[w_req_reg[gi]];
            assign w_is_ra[gi]  = (w_req_reg[gi] == RA_REG);
            assign w_accept[gi] = w_valid[gi] && w_ready[gi];
            assign w_issue[gi]  = w_accept[gi] && !w_is_ra[gi];
            assign w_stall[gi]  = w_valid[gi] && !w_accept[gi];
            // Edges seen in the boot-pulse cycle belong to the previous job.
            assign w_done[gi]   = (r_state[gi] == ACTIVE) && !r_boot[gi]
                                  && w_idle[gi] && !r_idle_prev[gi];
        end
    endgenerate

    // Grant: a lone eligible processor wins; a tie goes to the round-robin pointer.
    always_comb begin
        w_ready = 2'b00;
        if (&w_elig) begin
            w_ready[r_rr] = 1'b1;
        end else begin
            w_ready = w_elig;
        end
    end

    // Tracker next-state: FREE until an issued update, ACTIVE until completion.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_state_next[i] = r_state[i];
            case (r_state[i])
                FREE:    if (w_issue[i]) w_state_next[i] = ACTIVE;
                ACTIVE:  if (w_done[i])  w_state_next[i] = FREE;
                default: w_state_next[i] = FREE;
            endcase
        end
    end

    // Saturating conflict counter increment (0, 1 or 2 stalled requests).
    always_comb begin
        w_stall_n  = {1'b0, w_stall[0]} + {1'b0, w_stall[1]};
        w_cnt_sum  = {1'b0, r_conflict} + {{(CNT_WIDTH-1){1'b0}}, w_stall_n};
        w_cnt_next = w_cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_cnt_sum[CNT_WIDTH-1:0];
    end

    // State registers: trackers, locks, issue bus, pointer and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i]   <= FREE;
                r_trk_reg[i] <= '0;
            end
            r_boot         <= 2'b00;
            r_idle_prev    <= 2'b11;
            r_locked       <= '0;
            r_register_num <= '0;
            r_ra_reject    <= 1'b0;
            r_rr           <= 1'b0;
            r_conflict     <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= w_state_next[i];
                if (w_done[i])  r_locked[r_trk_reg[i]] <= 1'b0;
                if (w_issue[i]) begin
                    r_locked[w_req_reg[i]] <= 1'b1;
                    r_trk_reg[i]           <= w_req_reg[i];
                end
            end
            r_boot      <= w_issue;
            r_idle_prev <= w_idle;
            if (w_issue[0]) begin
                r_register_num <= w_req_reg[0];
            end else if (w_issue[1]) begin
                r_register_num <= w_req_reg[1];
            end
            r_ra_reject <= |(w_accept & w_is_ra);
            if (&w_elig) r_rr <= ~r_rr;
            r_conflict  <= w_cnt_next;
        end
    end

    assign req_ready_1           = w_ready[0];
    assign req_ready_2           = w_ready[1];
    assign boot_renew_register_1 = r_boot[0];
    assign boot_renew_register_2 = r_boot[1];
    assign register_num          = r_register_num;
    assign busy_1                = (r_state[0] == ACTIVE);
    assign busy_2                = (r_state[1] == ACTIVE);
    assign reg_locked            = r_locked;
    assign ra_reject             = r_ra_reject;
    assign conflict_count        = r_conflict;

endmodule
